// File: rtl/dsp_ccff_pkg.sv
// dsp_ccff_pkg: shared types and CRC-8 helper for the DSP configuration-chain loader.
// Contents: state_e (loader FSM states), CCFF_CRC_POLY (x^8+x^2+x+1), crc8_step (one bit-serial CRC step).
package dsp_ccff_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_VERIFY, ST_DONE} state_e;

    localparam logic [7:0] CCFF_CRC_POLY = 8'h07;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CCFF_CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/dsp_ccff_crc8.sv
// dsp_ccff_crc8: bit-serial CRC-8 accumulator (init 0x00) used for chain readback.
// Ports: prog_clk/pReset_n clock and async active-low reset; clr_i zeroes the CRC
// (priority over step); step_i folds bit_i into the CRC; crc_o is the current value.
module dsp_ccff_crc8
    import dsp_ccff_pkg::*;
(
    input  logic       prog_clk,
    input  logic       pReset_n,
    input  logic       clr_i,
    input  logic       step_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) crc_q <= '0;
        else if (clr_i) crc_q <= '0;
        else if (step_i) crc_q <= crc8_step(crc_q, bit_i);
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/dsp_ccff_loader.sv
// dsp_ccff_loader: streams configuration words LSB-first into the DSP tile's ccff chain.
// Ports: prog_clk, pReset_n (async active-low); start (begin load, IDLE only);
// cfg_valid/cfg_ready/cfg_data word stream; ccff_head/ccff_shift_en drive the chain,
// ccff_tail is the chain output; busy (not IDLE), done (1-cycle completion pulse),
// err (sticky readback mismatch).
// Macro DSP_CCFF_READBACK_EN adds a VERIFY pass that recirculates the chain and
// compares CRC-8 of the loaded bits against CRC-8 of the bits read back.
module dsp_ccff_loader
    import dsp_ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              cfg_valid,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BIT_W  = $clog2(CHAIN_LEN + 1);
    localparam int CNT_W  = $clog2(WORD_W + 1);
    localparam int WCNT_W = $clog2(NWORDS + 1);

    state_e            state_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [WORD_W-1:0] buf_q;
    logic [CNT_W-1:0]  buf_cnt_q;
    logic [WCNT_W-1:0] words_q;
    logic              head_q;
    logic              load, shift, hs, last;
    logic [31:0]       rem;
    logic [CNT_W-1:0]  fill;

    assign load      = state_q == ST_LOAD;
    assign shift     = load && buf_cnt_q != '0;
    assign hs        = cfg_valid && cfg_ready;
    assign last      = bit_cnt_q == BIT_W'(CHAIN_LEN - 1);
    // A refill may happen while the last buffered bit shifts out, so the stream has no bubble.
    assign cfg_ready = load && buf_cnt_q <= CNT_W'(1) && words_q < WCNT_W'(NWORDS);
    // The final word only contributes the bits still needed by the chain.
    assign rem       = 32'(CHAIN_LEN) - 32'(words_q) * 32'(WORD_W);
    assign fill      = rem >= 32'(WORD_W) ? CNT_W'(WORD_W) : CNT_W'(rem);
    assign busy      = state_q != ST_IDLE;
    assign done      = state_q == ST_DONE;

`ifdef DSP_CCFF_READBACK_EN
    logic       verify, err_q;
    logic [7:0] crc_load, crc_ver;

    assign verify        = state_q == ST_VERIFY;
    assign ccff_shift_en = shift || verify;
    // During VERIFY the tail is fed straight back so the chain contents survive the readback.
    assign ccff_head     = shift ? buf_q[0] : verify ? ccff_tail : head_q;
    assign err           = err_q;

    dsp_ccff_crc8 u_crc_load (
        .prog_clk (prog_clk),
        .pReset_n (pReset_n),
        .clr_i    (state_q == ST_IDLE && start),
        .step_i   (shift),
        .bit_i    (buf_q[0]),
        .crc_o    (crc_load)
    );

    dsp_ccff_crc8 u_crc_ver (
        .prog_clk (prog_clk),
        .pReset_n (pReset_n),
        .clr_i    (state_q == ST_IDLE && start),
        .step_i   (verify),
        .bit_i    (ccff_tail),
        .crc_o    (crc_ver)
    );
`else
    logic unused_tail;

    assign unused_tail   = ccff_tail;
    assign ccff_shift_en = shift;
    assign ccff_head     = shift ? buf_q[0] : head_q;
    assign err           = 1'b0;
`endif

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            buf_q     <= '0;
            buf_cnt_q <= '0;
            words_q   <= '0;
            head_q    <= 1'b0;
`ifdef DSP_CCFF_READBACK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_q   <= ST_LOAD;
                    bit_cnt_q <= '0;
                    buf_q     <= '0;
                    buf_cnt_q <= '0;
                    words_q   <= '0;
`ifdef DSP_CCFF_READBACK_EN
                    err_q     <= 1'b0;
`endif
                end
                ST_LOAD: begin
                    if (hs) begin
                        buf_q     <= cfg_data;
                        buf_cnt_q <= fill;
                        words_q   <= words_q + WCNT_W'(1);
                    end else if (shift) begin
                        buf_q     <= buf_q >> 1;
                        buf_cnt_q <= buf_cnt_q - CNT_W'(1);
                    end
                    if (shift) begin
                        head_q    <= buf_q[0];
                        bit_cnt_q <= last ? '0 : bit_cnt_q + BIT_W'(1);
`ifdef DSP_CCFF_READBACK_EN
                        if (last) state_q <= ST_VERIFY;
`else
                        if (last) state_q <= ST_DONE;
`endif
                    end
                end
`ifdef DSP_CCFF_READBACK_EN
                ST_VERIFY: begin
                    head_q    <= ccff_tail;
                    bit_cnt_q <= last ? '0 : bit_cnt_q + BIT_W'(1);
                    if (last) begin
                        // Compare against the verify CRC including this final tail bit.
                        err_q   <= crc_load != crc8_step(crc_ver, ccff_tail);
                        state_q <= ST_DONE;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dsp_ccff_loader.md
# dsp_ccff_loader

Programming-side controller for the DSP logical tile's configuration chain (`ccff_head` → `ccff_tail`). It accepts configuration words over a valid/ready stream and unpacks them LSB-first. It drives the chain serially, gated by a shift enable, for exactly `CHAIN_LEN` bits, then signals completion. It sits between the bitstream source and the DSP tile's configuration-chain flip-flops, on the programming clock domain.

## Interface
- `CHAIN_LEN`, default 64: number of configuration bits in the DSP tile chain; must be ≥ 2.
- `WORD_W`, default 8: input word width; must be ≥ 2.
- `prog_clk`  in  1: programming clock; all state is on its rising edge.
- `pReset_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle request to begin a load; honoured only in IDLE.
- `cfg_valid`  in  1: word on `cfg_data` is valid.
- `cfg_data`  in  WORD_W: configuration word, bit 0 shifted first.
- `cfg_ready`  out  1: loader accepts a word this cycle when `cfg_valid` is also high.
- `ccff_head`  out  1: serial bit into the chain.
- `ccff_tail`  in  1: serial bit out of the chain; used only when readback is compiled in.
- `ccff_shift_en`  out  1: chain shifts on this edge when high.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse when the load (and verify, if compiled in) completes.
- `err`  out  1: readback mismatch flag; sticky until the next accepted `start`; constant 0 without readback.

## Operation
- States: IDLE, LOAD, VERIFY (readback builds only), DONE.
- IDLE → LOAD on `start`. Entering LOAD clears the bit counter, the word buffer, and `err`.
- Word buffer:
  - `buf` holds the current word; `buf_cnt` holds the bits left in it.
  - A handshake (`cfg_valid & cfg_ready`) loads `buf`.
  - `buf_cnt` is loaded with min(`WORD_W`, `CHAIN_LEN` − bits already consumed).
  - Surplus high-order bits of the final word are discarded.
- `cfg_ready` = LOAD & (`buf_cnt` ≤ 1) & (words accepted < ceil(`CHAIN_LEN`/`WORD_W`)). Buffer refill therefore overlaps the last shift of the previous word, with no bubble.
- Shifting:
  - `ccff_shift_en` = LOAD & (`buf_cnt` > 0).
  - `ccff_head` = `buf[0]`, registered; it holds its last value when not shifting.
  - Each shift decrements `buf_cnt` and increments `bit_cnt`.
- When `cfg_valid` is low and the buffer is empty, there is no shift. This stall is legal and may last indefinitely.
- LOAD → DONE (or VERIFY) on the shift that makes `bit_cnt` = `CHAIN_LEN`.
- DONE: `done` = 1 for one cycle, then IDLE.
- `start` outside IDLE is ignored; no queueing.
- `cfg_valid` outside LOAD is ignored. `cfg_ready` is 0 outside LOAD.

## Timing
- Reset values: `cfg_ready` 0, `ccff_head` 0, `ccff_shift_en` 0, `busy` 0, `done` 0, `err` 0, state IDLE.
- `start` at edge N: LOAD from N+1. With `cfg_valid` held high, the first handshake is in cycle N+1 and the first shift in cycle N+2.
- Continuous stream load time: `CHAIN_LEN` consecutive shift cycles. `done` is asserted in the cycle after the last shift.
- Reset asserted mid-operation: every output returns immediately to its reset value. `done` is not pulsed. Chain contents are undefined.

## Configuration
- Macro `DSP_CCFF_READBACK_EN`.
- Defined:
  - During LOAD, a CRC-8 (poly 0x07, init 0x00, bit-serial: crc = {crc[6:0],0} ^ ((crc[7]^bit) ? 0x07 : 0)) accumulates every bit driven on `ccff_head`.
  - VERIFY runs `CHAIN_LEN` further shift cycles with `ccff_head` = `ccff_tail`. This recirculates the chain so its contents are preserved.
  - A second CRC accumulates `ccff_tail` over those cycles.
  - At the end, `err` = (crc_load ≠ crc_verify), then DONE.
  - `cfg_ready` is 0 throughout VERIFY.
- Not defined:
  - There is no VERIFY state or CRC logic.
  - `ccff_tail` is unused.
  - `err` is tied to 0.

## Structure
- Shared package `dsp_ccff_pkg`: the state enum, `CCFF_CRC_POLY` = 8'h07, and the `crc8_step` function.
- One sub-module, `dsp_ccff_crc8`, covering clear, step, and value. It is instantiated twice under `DSP_CCFF_READBACK_EN`.

## Test plan
- `CHAIN_LEN`=20, `WORD_W`=8, `cfg_valid` held high, words 0xA5, 0x3C, 0xFF → exactly 3 handshakes and exactly 20 `ccff_shift_en` cycles. The `ccff_head` sequence is 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0, then 1,1,1,1. `done` pulses in the cycle after the last shift.
- Same load with `cfg_valid` dropped for 5 cycles after the first word → `ccff_shift_en` is low for those stall cycles only. The same 20 bits are shifted and the total shift count is unchanged.
- `start` pulsed in cycle 3 of LOAD → no effect; one `done` only. A `start` 1 cycle after `done` → a new load begins.
- `pReset_n` asserted at bit 10 → all outputs are 0 immediately. A subsequent `start` performs a full 20-bit load.
- Readback build, behavioural 20-bit chain model → `err` = 0 after 40 shifts, and the model contents equal the loaded bits. A repeat run with the model forcing one bit flipped → `err` = 1 at `done`, and `err` is cleared by the next `start`.
